// File: rtl/frame_scanout_if.sv
// frame_scanout_if: scan control, SRAM burst read and pixel stream signals of frame_scanout
interface frame_scanout_if #(
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64
);
    logic                                        scan_en;
    logic                                        scan_done;
    logic                                        read_enable;
    logic [ADDR_SIZE_BITS-1:0]                   address;
    logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data;
    logic                                        pix_valid;
    logic                                        pix_ready;
    logic [WORD_SIZE_BYTES*8-1:0]                pix_data;
    logic                                        pix_first;
    logic                                        pix_last;
    modport master (
        input  scan_en, read_data, pix_ready,
        output scan_done, read_enable, address, pix_valid, pix_data, pix_first, pix_last
    );
    modport slave (
        output scan_en, read_data, pix_ready,
        input  scan_done, read_enable, address, pix_valid, pix_data, pix_first, pix_last
    );
endinterface

// File: rtl/frame_scanout.sv
// frame_scanout: fetches the frame from SRAM in bursts into ping-pong buffers and streams one pixel per cycle
module frame_scanout #(
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64,
    parameter int FRAME_BASE      = 0,
    parameter int FRAME_WORDS     = 65536
) (
    input logic             clk,
    input logic             n_rst,
    frame_scanout_if.master bus
);
    localparam int PW = WORD_SIZE_BYTES * 8;
    localparam int IW = $clog2(DATA_SIZE_WORDS);
    localparam int CW = $clog2(FRAME_WORDS) + 1;
    localparam logic [ADDR_SIZE_BITS-1:0] END_ADDR = ADDR_SIZE_BITS'(FRAME_BASE + FRAME_WORDS);
    typedef enum logic [2:0] {IDLE, REQ, CAP, DRAIN, DONE} state_t;
    state_t                             state_q, state_d;
    logic [DATA_SIZE_WORDS-1:0][PW-1:0] buf_q [2];
    logic [1:0]                         full_q, full_d;
    logic                               wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [IW-1:0]                      pix_idx_q, pix_idx_d;
    logic [CW-1:0]                      pix_cnt_q, pix_cnt_d;
    logic [ADDR_SIZE_BITS-1:0]          fetch_addr_q, fetch_addr_d;
    logic                               start, cap, xfer, rel, rd_en;
    assign start = (state_q == IDLE || state_q == DONE) && bus.scan_en;
    assign cap   = state_q == CAP;
    assign xfer  = bus.pix_valid && bus.pix_ready;
    assign rel   = xfer && pix_idx_q == IW'(DATA_SIZE_WORDS - 1);
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE, DONE: state_d = bus.scan_en ? REQ : state_q;
            REQ: begin
                rd_en   = fetch_addr_q != END_ADDR && !full_q[wr_sel_q];
                state_d = fetch_addr_q == END_ADDR ? DRAIN : rd_en ? CAP : REQ;
            end
            CAP:     state_d = REQ;
            DRAIN:   state_d = full_q == 2'b00 ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    // CAP only ever writes a non-full buffer, so capture and release never collide
    always_comb begin
        full_d = full_q;
        if (cap) full_d[wr_sel_q] = 1'b1;
        if (rel) full_d[rd_sel_q] = 1'b0;
        if (start) full_d = 2'b00;
        wr_sel_d     = start ? 1'b0 : wr_sel_q ^ cap;
        rd_sel_d     = start ? 1'b0 : rd_sel_q ^ rel;
        pix_idx_d    = start || rel ? '0 : pix_idx_q + IW'(xfer);
        pix_cnt_d    = start ? '0 : pix_cnt_q + CW'(xfer);
        fetch_addr_d = start ? ADDR_SIZE_BITS'(FRAME_BASE) :
                       cap ? fetch_addr_q + ADDR_SIZE_BITS'(DATA_SIZE_WORDS) : fetch_addr_q;
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            full_q       <= 2'b00;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            pix_idx_q    <= '0;
            pix_cnt_q    <= '0;
            fetch_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            pix_idx_q    <= pix_idx_d;
            pix_cnt_q    <= pix_cnt_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (cap) buf_q[wr_sel_q] <= bus.read_data;
    end
    assign bus.scan_done   = state_q == DONE;
    assign bus.read_enable = rd_en;
    assign bus.address     = rd_en ? fetch_addr_q : '0;
    assign bus.pix_valid   = full_q[rd_sel_q];
    assign bus.pix_data    = bus.pix_valid ? buf_q[rd_sel_q][pix_idx_q] : '0;
    assign bus.pix_first   = bus.pix_valid && pix_cnt_q == '0;
    assign bus.pix_last    = bus.pix_valid && pix_cnt_q == CW'(FRAME_WORDS - 1);
endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: scoreboard bench for frame_scanout with a 256-word frame and an address+k SRAM model
module tb_frame_scanout;
    localparam int FW = 256;
    localparam int BW = 64;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int checks = 0, errors = 0;
    int cyc = 0, rx = 0, c0 = 0, first_cyc = -1, last_cyc = -1, done_cyc = -1;
    logic [25:0] exp_q [$];
    logic [23:0] rd_addrs [$];
    logic [25:0] e;
    frame_scanout_if #(.ADDR_SIZE_BITS(24), .WORD_SIZE_BYTES(3), .DATA_SIZE_WORDS(BW)) bus ();
    frame_scanout #(.FRAME_WORDS(FW)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // SRAM model: burst word k holds address+k, presented the cycle after the strobe
    always @(posedge clk) begin
        if (bus.read_enable) begin
            rd_addrs.push_back(bus.address);
            for (int k = 0; k < BW; k++) bus.read_data[k*24 +: 24] <= 24'(bus.address + 24'(k));
        end
    end
    always @(negedge clk) begin
        if (n_rst && bus.pix_valid && bus.pix_ready) begin
            rx++;
            if (exp_q.size() == 0) chk("unexpected_pixel", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("pix_data", 64'(bus.pix_data), 64'(e[23:0]));
                chk("pix_first", 64'(bus.pix_first), 64'(e[24]));
                chk("pix_last", 64'(bus.pix_last), 64'(e[25]));
                if (e[24]) first_cyc = cyc;
                if (e[25]) last_cyc = cyc;
            end
        end
    end
    function automatic logic [63:0] outs();
        return 64'({bus.scan_done, bus.read_enable, bus.address, bus.pix_valid,
                    bus.pix_data, bus.pix_first, bus.pix_last});
    endfunction
    task automatic start_frame();
        for (int n = 0; n < FW; n++) exp_q.push_back({n == FW - 1, n == 0, 24'(n)});
        rd_addrs.delete();
        rx = 0;
        @(posedge clk) #1 bus.scan_en = 1'b1;
        c0 = cyc;
        @(posedge clk) #1 bus.scan_en = 1'b0;
        @(negedge clk);
        chk("start_read_enable", 64'(bus.read_enable), 64'd1);
        chk("start_address", 64'(bus.address), 64'd0);
        chk("start_scan_done", 64'(bus.scan_done), 64'd0);
    endtask
    task automatic wait_done(input bit rnd);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk) #1;
            if (rnd) bus.pix_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.scan_done) begin
                done_cyc = cyc;
                bus.pix_ready = 1'b1;
                return;
            end
        end
        chk("done_timeout", 64'd0, 64'd1);
    endtask
    task automatic check_reads();
        chk("read_count", 64'(rd_addrs.size()), 64'(FW / BW));
        for (int k = 0; k < rd_addrs.size() && k < FW / BW; k++)
            chk("read_addr", 64'(rd_addrs[k]), 64'(k * BW));
    endtask
    initial begin
        bus.scan_en = 1'b0;
        bus.pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("in_reset_outputs", outs(), 64'd0);
        @(posedge clk) #1 n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", outs(), 64'd0);
        end
        // full frame, sink always ready
        bus.pix_ready = 1'b1;
        start_frame();
        wait_done(1'b0);
        chk("first_latency", 64'(first_cyc - c0), 64'd3);
        chk("gap_free_span", 64'(last_cyc - first_cyc), 64'(FW - 1));
        chk("done_after_last", 64'(done_cyc - last_cyc), 64'd2);
        chk("rx_count", 64'(rx), 64'(FW));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        check_reads();
        // backpressure held for 100 cycles after the first pixel appears
        bus.pix_ready = 1'b0;
        start_frame();
        @(negedge clk);
        @(negedge clk);
        chk("bp_first_valid", 64'(bus.pix_valid), 64'd1);
        chk("bp_first_flag", 64'(bus.pix_first), 64'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(bus.pix_valid), 64'd1);
            chk("bp_hold_data", 64'(bus.pix_data), 64'd0);
            if (i >= 3) chk("bp_no_read", 64'(bus.read_enable), 64'd0);
        end
        chk("bp_bursts_fetched", 64'(rd_addrs.size()), 64'd2);
        @(posedge clk) #1 bus.pix_ready = 1'b1;
        wait_done(1'b0);
        chk("bp_rx_count", 64'(rx), 64'(FW));
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        check_reads();
        // random sink readiness
        start_frame();
        wait_done(1'b1);
        chk("rnd_rx_count", 64'(rx), 64'(FW));
        chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
        // reset at pixel 100
        start_frame();
        for (int i = 0; i < 1000 && rx < 100; i++) @(posedge clk);
        chk("reached_px100", 64'(rx >= 100), 64'd1);
        #1 n_rst = 1'b0;
        #1 chk("abort_outputs", outs(), 64'd0);
        exp_q.delete();
        @(posedge clk) #1 n_rst = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", outs(), 64'd0);
        start_frame();
        wait_done(1'b0);
        chk("restart_rx_count", 64'(rx), 64'(FW));
        chk("restart_queue_empty", 64'(exp_q.size()), 64'd0);
        check_reads();
        // scan_en mid-frame is ignored, then honoured in DONE
        start_frame();
        repeat (50) @(posedge clk);
        #1 bus.scan_en = 1'b1;
        @(posedge clk) #1 bus.scan_en = 1'b0;
        wait_done(1'b0);
        chk("mid_rx_count", 64'(rx), 64'(FW));
        chk("mid_queue_empty", 64'(exp_q.size()), 64'd0);
        check_reads();
        start_frame();
        wait_done(1'b0);
        chk("again_rx_count", 64'(rx), 64'(FW));
        chk("again_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
